// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 pixel sink: ILI9341 commands, bus FSM encoding
// and the per-pixel word table.
package lt24_pkg;

    localparam logic [15:0] CMD_CASET  = 16'h002A;
    localparam logic [15:0] CMD_PASET  = 16'h002B;
    localparam logic [15:0] CMD_RAMWR  = 16'h002C;
    localparam int          WORD_COUNT = 12;
    localparam logic [3:0]  LAST_WORD  = 4'(WORD_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_WR_LOW  = 2'd2,
        ST_WR_HIGH = 2'd3
    } bus_state_t;

    typedef struct packed {
        logic        rs;
        logic [15:0] data;
    } bus_word_t;

    // Column window is x..x, page window is y..y, then a single RAM write.
    function automatic bus_word_t word_lookup(
        input logic [3:0]  idx,
        input logic [7:0]  x,
        input logic [8:0]  y,
        input logic [15:0] colour
    );
        bus_word_t w;
        case (idx)
            4'd0:    w = '{rs: 1'b0, data: CMD_CASET};
            4'd1:    w = '{rs: 1'b1, data: 16'h0000};
            4'd2:    w = '{rs: 1'b1, data: {8'h00, x}};
            4'd3:    w = '{rs: 1'b1, data: 16'h0000};
            4'd4:    w = '{rs: 1'b1, data: {8'h00, x}};
            4'd5:    w = '{rs: 1'b0, data: CMD_PASET};
            4'd6:    w = '{rs: 1'b1, data: {15'h0000, y[8]}};
            4'd7:    w = '{rs: 1'b1, data: {8'h00, y[7:0]}};
            4'd8:    w = '{rs: 1'b1, data: {15'h0000, y[8]}};
            4'd9:    w = '{rs: 1'b1, data: {8'h00, y[7:0]}};
            4'd10:   w = '{rs: 1'b0, data: CMD_RAMWR};
            4'd11:   w = '{rs: 1'b1, data: colour};
            default: w = '{rs: 1'b1, data: 16'h0000};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lt24_pixel_sink_if.sv
// Pixel request handshake plus the LT24 8080 write pins, bundled for the pixel sink.
interface lt24_pixel_sink_if;

    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic        LT24Wr_n;
    logic        LT24Rd_n;
    logic        LT24CS_n;
    logic        LT24RS;
    logic [15:0] LT24Data;

    modport master (
        output xAddr, yAddr, pixelData, pixelWrite,
        input  pixelReady, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Data
    );

    modport slave (
        input  xAddr, yAddr, pixelData, pixelWrite,
        output pixelReady, LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Data
    );

endinterface

// File: rtl/lt24_bus_cycle.sv
// One-word 8080 write strobe: SETUP, WR_LOW, WR_HIGH. A start seen in the last
// WR_HIGH cycle chains straight into the next word's SETUP.
module lt24_bus_cycle
    import lt24_pkg::*;
#(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        word_rs,
    input  logic [15:0] word_data,
    output logic        done,
    output logic        wr_n,
    output logic        rs,
    output logic [15:0] data
);

    localparam int PHASE_MAX = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int CW        = $clog2(PHASE_MAX + 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW_CYCLES - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH_CYCLES - 1);

    bus_state_t    state_r, state_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic          wr_n_r, wr_n_nxt;
    logic          rs_r, rs_nxt;
    logic [15:0]   data_r, data_nxt;
    logic          done_s;

    // State register; strobe, RS and data are registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            wr_n_r  <= 1'b1;
            rs_r    <= 1'b1;
            data_r  <= 16'h0000;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            wr_n_r  <= wr_n_nxt;
            rs_r    <= rs_nxt;
            data_r  <= data_nxt;
        end
    end

    // Next-state and phase counter.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_WR_LOW;
                cnt_nxt   = '0;
            end
            ST_WR_LOW: begin
                if (cnt_r == LOW_LAST) begin
                    state_nxt = ST_WR_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_r + CW'(1);
                end
            end
            ST_WR_HIGH: begin
                if (cnt_r == HIGH_LAST) begin
                    state_nxt = start ? ST_SETUP : ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: RS/data load only on entry to SETUP and hold for the word.
    always_comb begin
        done_s   = (state_r == ST_WR_HIGH) && (cnt_r == HIGH_LAST);
        wr_n_nxt = (state_nxt != ST_WR_LOW);
        if (start && (state_nxt == ST_SETUP)) begin
            rs_nxt   = word_rs;
            data_nxt = word_data;
        end else begin
            rs_nxt   = rs_r;
            data_nxt = data_r;
        end
    end

    assign done = done_s;
    assign wr_n = wr_n_r;
    assign rs   = rs_r;
    assign data = data_r;

endmodule

// File: rtl/lt24_pixel_sink.sv
// Accepts one pixel per handshake and emits the 12-word CASET/PASET/RAMWR burst
// to the LT24 panel; out-of-range pixels are swallowed without bus activity.
module lt24_pixel_sink
    import lt24_pkg::*;
#(
    parameter int WIDTH          = 240,
    parameter int HEIGHT         = 320,
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2
) (
    input logic              clock,
    input logic              globalReset,
    lt24_pixel_sink_if.slave bus
);

    logic        pixel_ready_r;
    logic        cs_n_r;
    logic [3:0]  idx_r;
    logic [7:0]  x_r;
    logic [8:0]  y_r;
    logic [15:0] colour_r;

    logic        accept_s;
    logic        in_range_s;
    logic        start_s;
    logic        done_s;
    logic [3:0]  word_sel_s;
    bus_word_t   word_s;
    logic        wr_n_s;
    logic        rs_s;
    logic [15:0] data_s;

    // Word 0 is a constant command, so it can be issued before the latches update.
    always_comb begin
        accept_s   = pixel_ready_r & bus.pixelWrite;
        in_range_s = (32'(bus.xAddr) < 32'(WIDTH)) && (32'(bus.yAddr) < 32'(HEIGHT));
        word_sel_s = accept_s ? 4'd0 : (idx_r + 4'd1);
        start_s    = (accept_s & in_range_s) | (done_s & (idx_r != LAST_WORD));
        word_s     = word_lookup(word_sel_s, x_r, y_r, colour_r);
    end

    // Accept, latching, word sequencing, chip select and ready.
    always_ff @(posedge clock or posedge globalReset) begin
        if (globalReset) begin
            pixel_ready_r <= 1'b0;
            cs_n_r        <= 1'b1;
            idx_r         <= 4'd0;
            x_r           <= 8'd0;
            y_r           <= 9'd0;
            colour_r      <= 16'h0000;
        end else if (accept_s) begin
            pixel_ready_r <= 1'b0;
            cs_n_r        <= ~in_range_s;
            idx_r         <= 4'd0;
            x_r           <= bus.xAddr;
            y_r           <= bus.yAddr;
            colour_r      <= bus.pixelData;
        end else if (!pixel_ready_r && cs_n_r) begin
            // Out of reset or after a discarded pixel: ready again next cycle.
            pixel_ready_r <= 1'b1;
        end else if (done_s) begin
            if (idx_r == LAST_WORD) begin
                cs_n_r        <= 1'b1;
                pixel_ready_r <= 1'b1;
            end else begin
                idx_r <= idx_r + 4'd1;
            end
        end else begin
            pixel_ready_r <= pixel_ready_r;
        end
    end

    lt24_bus_cycle #(
        .WR_LOW_CYCLES (WR_LOW_CYCLES),
        .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
    ) u_bus_cycle (
        .clk      (clock),
        .rst      (globalReset),
        .start    (start_s),
        .word_rs  (word_s.rs),
        .word_data(word_s.data),
        .done     (done_s),
        .wr_n     (wr_n_s),
        .rs       (rs_s),
        .data     (data_s)
    );

    assign bus.pixelReady = pixel_ready_r;
    assign bus.LT24CS_n   = cs_n_r;
    assign bus.LT24Rd_n   = 1'b1;
    assign bus.LT24Wr_n   = wr_n_s;
    assign bus.LT24RS     = rs_s;
    assign bus.LT24Data   = data_s;

endmodule

// File: tb/tb_lt24_pixel_sink.sv
// Bench for lt24_pixel_sink: default-timing DUT (index 0) and a 1/3 strobe DUT (index 1)
// share clock and reset; a bus monitor pops expected words and ready-low lengths.
module tb_lt24_pixel_sink;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lt24_pixel_sink_if pa ();
    lt24_pixel_sink_if pb ();

    lt24_pixel_sink dut_a (
        .clock      (clk),
        .globalReset(rst),
        .bus        (pa.slave)
    );

    lt24_pixel_sink #(
        .WIDTH         (240),
        .HEIGHT        (320),
        .WR_LOW_CYCLES (1),
        .WR_HIGH_CYCLES(3)
    ) dut_b (
        .clock      (clk),
        .globalReset(rst),
        .bus        (pb.slave)
    );

    logic [1:0]  wr_v, cs_v, rd_v, rs_v, rdy_v;
    logic [15:0] dat_v [2];
    assign wr_v     = {pb.LT24Wr_n, pa.LT24Wr_n};
    assign cs_v     = {pb.LT24CS_n, pa.LT24CS_n};
    assign rd_v     = {pb.LT24Rd_n, pa.LT24Rd_n};
    assign rs_v     = {pb.LT24RS, pa.LT24RS};
    assign rdy_v    = {pb.pixelReady, pa.pixelReady};
    assign dat_v[0] = pa.LT24Data;
    assign dat_v[1] = pb.LT24Data;

    int checks = 0;
    int errors = 0;

    typedef struct { int dut; logic [16:0] word; } exp_word_t;
    typedef struct { int dut; int len; } exp_rdy_t;
    exp_word_t word_q [$];
    exp_rdy_t  rdy_q [$];

    logic [16:0] spec_words [12] = '{17'h0002A, 17'h10000, 17'h1000A, 17'h10000, 17'h1000A,
        17'h0002B, 17'h10001, 17'h1002C, 17'h10001, 17'h1002C, 17'h0002C, 17'h1F800};

    logic        prev_wr [2];
    logic        prev_cs [2];
    logic        seen_ready [2];
    logic [16:0] fall_word [2];
    int low_run [2]        = '{0, 0};
    int high_run [2]       = '{0, 0};
    int words_in_burst [2] = '{0, 0};
    int ready_run [2]      = '{0, 0};
    int pulses [2]         = '{0, 0};
    int cs_low_cnt [2]     = '{0, 0};

    function automatic int lo(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int hi(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [16:0] model_word(input int k, input logic [7:0] x,
                                               input logic [8:0] y, input logic [15:0] col);
        logic [16:0] w [12];
        w = '{{1'b0, 16'h002A}, {1'b1, 16'h0000}, {1'b1, 8'h00, x}, {1'b1, 16'h0000},
              {1'b1, 8'h00, x}, {1'b0, 16'h002B}, {1'b1, 15'h0000, y[8]}, {1'b1, 8'h00, y[7:0]},
              {1'b1, 15'h0000, y[8]}, {1'b1, 8'h00, y[7:0]}, {1'b0, 16'h002C}, {1'b1, col}};
        return w[k];
    endfunction

    task automatic push_burst(input int d, input logic [7:0] x, input logic [8:0] y,
                              input logic [15:0] col, input logic inr, input logic use_spec);
        exp_word_t e;
        exp_rdy_t  r;
        r.dut = d;
        if (inr) begin
            for (int k = 0; k < 12; k++) begin
                e.dut  = d;
                e.word = use_spec ? spec_words[k] : model_word(k, x, y, col);
                word_q.push_back(e);
            end
            r.len = 60;
        end else begin
            r.len = 1;
        end
        rdy_q.push_back(r);
    endtask

    task automatic pop_word(input int d, input logic [16:0] actual);
        exp_word_t e;
        if (word_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word dut %0d: got 0x%05h, want no bus write", d, actual);
        end else begin
            e = word_q.pop_front();
            check("word_dut", d, e.dut);
            check("bus_word", actual, e.word);
        end
    endtask

    task automatic pop_rdy(input int d, input int len);
        exp_rdy_t r;
        if (rdy_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready_low dut %0d: got run of %0d, want none", d, len);
        end else begin
            r = rdy_q.pop_front();
            check("ready_dut", d, r.dut);
            check("ready_low_len", len, r.len);
        end
    endtask

    task automatic monitor_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                prev_wr[d]        = 1'b1;
                prev_cs[d]        = 1'b1;
                seen_ready[d]     = 1'b0;
                low_run[d]        = 0;
                high_run[d]       = 0;
                words_in_burst[d] = 0;
                ready_run[d]      = 0;
            end else begin
                check("rd_n_high", rd_v[d], 1);
                if (!prev_cs[d] && cs_v[d]) begin
                    check("cs_end_high_len", high_run[d], hi(d));
                    check("burst_word_count", words_in_burst[d], 12);
                    words_in_burst[d] = 0;
                end
                if (!cs_v[d]) cs_low_cnt[d]++;
                if (!wr_v[d]) begin
                    if (prev_wr[d]) begin
                        check("wr_low_inside_cs", cs_v[d], 0);
                        check("wr_high_len", high_run[d], (words_in_burst[d] == 0) ? 1 : hi(d) + 1);
                        fall_word[d] = {rs_v[d], dat_v[d]};
                    end
                    low_run[d]++;
                    high_run[d] = 0;
                end else begin
                    if (!prev_wr[d]) begin
                        check("wr_low_len", low_run[d], lo(d));
                        check("word_stable", {rs_v[d], dat_v[d]}, fall_word[d]);
                        pop_word(d, {rs_v[d], dat_v[d]});
                        words_in_burst[d]++;
                        pulses[d]++;
                    end
                    low_run[d]  = 0;
                    high_run[d] = cs_v[d] ? 0 : high_run[d] + 1;
                end
                if (rdy_v[d]) begin
                    if (seen_ready[d] && ready_run[d] > 0) pop_rdy(d, ready_run[d]);
                    ready_run[d]  = 0;
                    seen_ready[d] = 1'b1;
                end else if (seen_ready[d]) begin
                    ready_run[d]++;
                end
                prev_wr[d] = wr_v[d];
                prev_cs[d] = cs_v[d];
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    task automatic drive(input int d, input logic [7:0] x, input logic [8:0] y,
                         input logic [15:0] c, input logic w);
        if (d == 0) begin
            pa.xAddr = x; pa.yAddr = y; pa.pixelData = c; pa.pixelWrite = w;
        end else begin
            pb.xAddr = x; pb.yAddr = y; pb.pixelData = c; pb.pixelWrite = w;
        end
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (!rdy_v[d] && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        if (!rdy_v[d]) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut %0d: pixelReady 0 after %0d cycles, want 1", d, n);
        end
    endtask

    task automatic send_pixel(input int d, input logic [7:0] x, input logic [8:0] y,
                              input logic [15:0] c, input logic inr, input logic use_spec);
        wait_ready(d);
        drive(d, x, y, c, 1'b1);
        push_burst(d, x, y, c, inr, use_spec);
        @(posedge clk); #2;
        drive(d, ~x, ~y, ~c, 1'b0);
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] col;
        logic        in_range;
        logic        use_spec;
        int          dut;
    } vec_t;
    vec_t vecs [8];

    initial begin
        int p0, c0, n, acc;
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] c;

        vecs[0] = '{8'd10,  9'd300, 16'hF800, 1'b1, 1'b1, 0};
        vecs[1] = '{8'd240, 9'd5,   16'h1234, 1'b0, 1'b0, 0};
        vecs[2] = '{8'd239, 9'd319, 16'h07E0, 1'b1, 1'b0, 0};
        vecs[3] = '{8'd0,   9'd320, 16'hFFFF, 1'b0, 1'b0, 0};
        vecs[4] = '{8'd255, 9'd511, 16'hAAAA, 1'b0, 1'b0, 0};
        vecs[5] = '{8'd0,   9'd0,   16'h001F, 1'b1, 1'b0, 0};
        vecs[6] = '{8'd10,  9'd300, 16'hF800, 1'b1, 1'b1, 1};
        vecs[7] = '{8'd128, 9'd256, 16'h5A5A, 1'b1, 1'b0, 1};

        drive(0, 8'd0, 9'd0, 16'h0000, 1'b0);
        drive(1, 8'd0, 9'd0, 16'h0000, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", rdy_v[d], 0);
            check("reset_cs_n", cs_v[d], 1);
            check("reset_wr_n", wr_v[d], 1);
            check("reset_rd_n", rd_v[d], 1);
            check("reset_rs", rs_v[d], 1);
            check("reset_data", dat_v[d], 16'h0000);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_before_edge", rdy_v, 2'b00);
        @(posedge clk); #2;
        check("ready_after_edge", rdy_v, 2'b11);
        check("idle_cs_n", cs_v, 2'b11);

        for (int i = 0; i < 8; i++) begin
            p0 = pulses[vecs[i].dut];
            c0 = cs_low_cnt[vecs[i].dut];
            send_pixel(vecs[i].dut, vecs[i].x, vecs[i].y, vecs[i].col, vecs[i].in_range, vecs[i].use_spec);
            wait_ready(vecs[i].dut);
            check("vec_pulses", pulses[vecs[i].dut] - p0, vecs[i].in_range ? 12 : 0);
            check("vec_cs_low_cycles", cs_low_cnt[vecs[i].dut] - c0, vecs[i].in_range ? 60 : 0);
        end

        // pixelWrite held high with fresh data every cycle
        p0 = pulses[0];
        wait_ready(0);
        n = 0;
        acc = 0;
        while (acc < 3 && n < 400) begin
            c = 16'($urandom);
            x = 8'($urandom_range(0, 239));
            y = 9'($urandom_range(0, 319));
            drive(0, x, y, c, 1'b1);
            if (rdy_v[0]) begin
                push_burst(0, x, y, c, 1'b1, 1'b0);
                acc++;
            end
            @(posedge clk); #2;
            n++;
        end
        drive(0, 8'd0, 9'd0, 16'h0000, 1'b0);
        check("stream_accepts", acc, 3);
        wait_ready(0);
        check("stream_pulses", pulses[0] - p0, 36);

        // reset in the middle of a burst
        send_pixel(0, 8'd50, 9'd100, 16'h1357, 1'b1, 1'b0);
        n = 0;
        while (words_in_burst[0] < 6 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("reach_word6", words_in_burst[0], 6);
        rst = 1'b1;
        #1;
        check("midrst_cs_n", cs_v[0], 1);
        check("midrst_wr_n", wr_v[0], 1);
        check("midrst_ready", rdy_v[0], 0);
        word_q.delete();
        rdy_q.delete();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk); #2;
        check("postrst_ready", rdy_v, 2'b11);
        p0 = pulses[0];
        c0 = cs_low_cnt[0];
        send_pixel(0, 8'd77, 9'd288, 16'hC0DE, 1'b1, 1'b0);
        wait_ready(0);
        check("postrst_pulses", pulses[0] - p0, 12);
        check("postrst_cs_low_cycles", cs_low_cnt[0] - c0, 60);

        repeat (5) @(posedge clk);
        #2;
        check("word_queue_empty", word_q.size(), 0);
        check("ready_queue_empty", rdy_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
